keypad_scan: RTL
================

# keypad_scan

Matrix keypad scanner for the clock board's time-setting keys. It is the input-direction counterpart of the multiplexed 7-segment display driver. It walks four active-low row strobes at a fixed slot rate and samples four pulled-up column lines. It debounces whole-matrix scan results and delivers a 4-bit hex key code with a one-cycle press strobe and a held level to the timekeeping logic.

## Interface
- `SCAN_DIV`, 5000, clock cycles per row slot; must be ≥4.
- `DEBOUNCE_SCANS`, 4, consecutive identical full scans needed to accept a press or a release; must be ≥2 and ≤15.
- `CLK` input 1: system clock, 50 MHz.
- `RST_N` input 1: synchronous, active-low reset.
- `COL` input 4: column sense lines, active-low, externally pulled up.
- `ROW` output 4: row strobes, one-cold.
- `KEY` output 4: code of the last accepted key.
- `KEY_VALID` output 1: one-cycle pulse when a press is accepted.
- `KEY_HELD` output 1: high from press acceptance until release acceptance.

## Operation
- **COL synchronizer:** two-flop, reset value 4'b1111. All scan logic uses the synchronized value.
- **Row driving:**
  - Row index `r` (0..3) and slot counter (0..SCAN_DIV-1).
  - `ROW = ~(4'b0001 << r)`, registered.
  - Columns are sampled on the cycle where slot == SCAN_DIV-1. On that same cycle the slot counter wraps and `r` increments mod 4.
- **Per-scan accumulation:**
  - Each sampled low column at (r,c) is a hit.
  - Hit count saturates at 2.
  - The first hit in scan order (row 0 before row 3, col 0 before col 3) is latched as the candidate code.
- **scan_done:** a one-cycle internal pulse on the row-3 sample. It publishes the scan result, then the accumulators clear.
  - NONE: 0 hits.
  - SINGLE(code): 1 hit.
  - MULTI: ≥2 hits, treated as no valid key (ghosting).
- **Key map:**
  - row0: 1,2,3,A
  - row1: 4,5,6,B
  - row2: 7,8,9,C
  - row3: E(*),0,F(#),D
- **Debounce FSM:** advances only on scan_done; match counter `n`.
  - RELEASED: on SINGLE(k), set cand=k, n=1, go to PRESS_PEND. Otherwise stay.
  - PRESS_PEND: on SINGLE(cand), n++. When n reaches DEBOUNCE_SCANS, go to PRESSED, set KEY=cand, pulse KEY_VALID. On anything else (NONE, MULTI, other key), go to RELEASED.
  - PRESSED: KEY_HELD=1. On any result other than SINGLE(cand), set n=1 and go to RELEASE_PEND.
  - RELEASE_PEND: KEY_HELD stays 1. On SINGLE(cand), return to PRESSED. Otherwise n++; when n reaches DEBOUNCE_SCANS, go to RELEASED and set KEY_HELD=0.
- **Key rollover:** while a key is held, a different key only registers after the held key's release is accepted, followed by DEBOUNCE_SCANS fresh scans of the new key. No N-key rollover.
- **KEY hold:** KEY keeps its value after release until the next accepted press.

## Timing
- **Reset values:**
  - ROW=4'b1110, r=0, slot=0.
  - KEY=4'h0, KEY_VALID=0, KEY_HELD=0.
  - FSM=RELEASED, n=0, accumulators cleared.
- **Reset mid-scan or mid-press:** everything returns to the reset values. A key already down is re-debounced from scratch, so KEY_VALID fires again after DEBOUNCE_SCANS scans.
- **Scan period:** 4·SCAN_DIV cycles; 400 µs at the defaults.
- **Settling:** the sample point is SCAN_DIV-1 cycles after the ROW change, which covers the 2-cycle synchronizer plus board settling.
- **Press latency:** KEY_VALID and KEY_HELD rise together, one cycle after the scan_done of the DEBOUNCE_SCANS-th consecutive SINGLE(k) scan.
- **Release latency:** KEY_HELD falls one cycle after the scan_done of the DEBOUNCE_SCANS-th consecutive non-matching scan.
- **Transitions between scans:** a key change between row samples of one scan is judged per row sample; the resulting mixed scan counts as whatever hits were seen.

## Structure
- **`keypad_pkg`:**
  - debounce state enum (RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND)
  - scan-result kind enum (NONE, SINGLE, MULTI)
  - 16-entry key-map constant indexed by {r,c}
- **Sub-module `keypad_debounce`:** the FSM plus n counter.
  - Inputs: scan_done, result kind, code.
  - Outputs: KEY, KEY_VALID, KEY_HELD.
- **Top `keypad_scan`:** synchronizer, row/slot counters and accumulator.

## Test plan
Bench parameters: SCAN_DIV=8, DEBOUNCE_SCANS=3 (scan period 32 cycles). COL is modelled from a pressed-switch set against the current ROW.
- **Reset:** hold RST_N=0 for 5 cycles -> ROW=1110, KEY=0, KEY_VALID=0, KEY_HELD=0. ROW advances to 1101 on cycle 8 after release.
- **Single press:** press row1/col2 steadily -> exactly one KEY_VALID pulse, KEY=4'h6, KEY_HELD=1 one cycle after the 3rd scan_done.
  - Release -> KEY_HELD=0 after 3 empty scans.
  - KEY stays 6.
- **Bounce:** press row3/col1 with contact toggled every 20 cycles for 100 cycles, then steady -> no KEY_VALID during bouncing. One KEY_VALID with KEY=4'h0 three stable scans later.
- **Ghosting:** row0/col0 and row2/col3 held together -> MULTI every scan, no KEY_VALID.
  - Releasing row2/col3 -> KEY=4'h1 accepted after 3 scans.
- **Rollover:** hold 4'h5; press 4'h9 and release 5 within one scan -> KEY_HELD drops after 3 scans, then KEY_VALID with KEY=9 after 3 more.
- **Mid-press reset:** RST_N low for one cycle while 4'hA is held -> outputs reset, KEY_VALID with KEY=A again 3 scans later.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state/result types and the row/column-to-hex key map
package keypad_pkg;
    typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND} deb_state_e;
    typedef enum logic [1:0] {NONE, SINGLE, MULTI} res_kind_e;
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };
endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: accepts presses/releases after DEBOUNCE_SCANS consistent scan results
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_done,
    input  res_kind_e  kind,
    input  logic [3:0] code,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);
    localparam logic [3:0] LAST = 4'(DEBOUNCE_SCANS);
    deb_state_e state_q, state_d;
    logic [3:0] n_q, n_d, cand_q, cand_d, key_q, key_d;
    logic       valid_q, valid_d, held_q, held_d, hit;
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cand_d  = cand_q;
        key_d   = key_q;
        valid_d = 1'b0;
        hit     = (kind == SINGLE) && (code == cand_q);
        if (scan_done) begin
            unique case (state_q)
                RELEASED: if (kind == SINGLE) begin
                    cand_d  = code;
                    n_d     = 4'd1;
                    state_d = PRESS_PEND;
                end
                PRESS_PEND: if (!hit) state_d = RELEASED;
                else begin
                    n_d = n_q + 4'd1;
                    if (n_d == LAST) begin
                        state_d = PRESSED;
                        key_d   = cand_q;
                        valid_d = 1'b1;
                    end
                end
                PRESSED: if (!hit) begin
                    n_d     = 4'd1;
                    state_d = RELEASE_PEND;
                end
                RELEASE_PEND: if (hit) state_d = PRESSED;
                else begin
                    n_d = n_q + 4'd1;
                    if (n_d == LAST) state_d = RELEASED;
                end
                default: state_d = RELEASED;
            endcase
        end
        held_d = (state_d == PRESSED) || (state_d == RELEASE_PEND);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RELEASED;
            n_q     <= 4'd0;
            cand_q  <= 4'h0;
            key_q   <= 4'h0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cand_q  <= cand_d;
            key_q   <= key_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end
    assign key       = key_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: strobes 4 rows, samples synchronized columns, classifies each full scan
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 5000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] COL,
    output logic [3:0] ROW,
    output logic [3:0] KEY,
    output logic       KEY_VALID,
    output logic       KEY_HELD
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    logic [3:0]    col_s1_q, col_s2_q, row_q, row_d, code_q, code_d, acc_code, low;
    logic [SW-1:0] slot_q, slot_d;
    logic [1:0]    r_q, r_d, hits_q, hits_d, hits_sat, first_c;
    logic [2:0]    row_cnt, sum;
    logic          sample, scan_done;
    res_kind_e     kind;
    always_comb begin
        sample    = slot_q == SLOT_LAST;
        low       = ~col_s2_q;
        row_cnt   = 3'(low[0]) + 3'(low[1]) + 3'(low[2]) + 3'(low[3]);
        sum       = {1'b0, hits_q} + row_cnt;
        hits_sat  = sum >= 3'd2 ? 2'd2 : sum[1:0];
        first_c   = low[0] ? 2'd0 : low[1] ? 2'd1 : low[2] ? 2'd2 : 2'd3;
        // only the first hit of the scan names the candidate key
        acc_code  = (hits_q == 2'd0 && row_cnt != 3'd0) ? KEY_MAP[{r_q, first_c}] : code_q;
        scan_done = sample && r_q == 2'd3;
        kind      = hits_sat == 2'd0 ? NONE : hits_sat == 2'd1 ? SINGLE : MULTI;
        slot_d    = sample ? '0 : slot_q + SW'(1);
        r_d       = sample ? r_q + 2'd1 : r_q;
        row_d     = ~(4'b0001 << r_d);
        hits_d    = scan_done ? 2'd0 : sample ? hits_sat : hits_q;
        code_d    = scan_done ? 4'h0 : sample ? acc_code : code_q;
    end
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            col_s1_q <= 4'hF;
            col_s2_q <= 4'hF;
            slot_q   <= '0;
            r_q      <= 2'd0;
            row_q    <= 4'b1110;
            hits_q   <= 2'd0;
            code_q   <= 4'h0;
        end else begin
            col_s1_q <= COL;
            col_s2_q <= col_s1_q;
            slot_q   <= slot_d;
            r_q      <= r_d;
            row_q    <= row_d;
            hits_q   <= hits_d;
            code_q   <= code_d;
        end
    end
    assign ROW = row_q;
    keypad_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
        .clk       (CLK),
        .rst_n     (RST_N),
        .scan_done (scan_done),
        .kind      (kind),
        .code      (acc_code),
        .key       (KEY),
        .key_valid (KEY_VALID),
        .key_held  (KEY_HELD)
    );
endmodule
